// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit serial LFSR pattern generator: regenerates the sequence,
// acquires bit alignment by slipping, declares lock and counts errors. Optional LFSR_CHECKER_BITCNT_EN adds the bit counter.
module lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_LIMIT = 8,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seed_load,
  input  logic                 enable,
  input  logic                 in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [31:0]          bit_count
);

  localparam logic [15:0] SEED      = 16'hAAAA;
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]  LOSS_LAST = 8'(LOSS_LIMIT - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic        exp_bit;
  logic        enable_q;
  logic        slip;
  logic [7:0]  match_cnt;
  logic [7:0]  miss_cnt;

  logic        cmp;
  logic        mismatch;
  logic        hunt_cmp;
  logic        lock_cmp;
  logic        hunt_miss;
  logic        lock_miss;

  // Galois step, taps at bits 3/4/5 fed from the outgoing msb.
  always_comb begin
    lfsr_nxt = {lfsr[14:0], lfsr[15]} ^ {10'd0, {3{lfsr[15]}}, 3'd0};
  end

  always_comb begin
    cmp       = enable_q;
    mismatch  = in ^ exp_bit;
    hunt_cmp  = cmp && !seed_load && (state == HUNT);
    lock_cmp  = cmp && !seed_load && (state == LOCKED);
    hunt_miss = hunt_cmp && mismatch;
    lock_miss = lock_cmp && mismatch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr     <= SEED;
      exp_bit  <= 1'b0;
      enable_q <= 1'b0;
      slip     <= 1'b0;
    end else begin
      exp_bit  <= lfsr[0];
      enable_q <= enable;
      slip     <= hunt_miss;
      if (seed_load) begin
        lfsr <= SEED;
      end else if (enable && !slip) begin
        lfsr <= lfsr_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (seed_load) begin
      state_nxt = HUNT;
    end else begin
      unique case (state)
        HUNT: begin
          if (hunt_cmp && !mismatch && (match_cnt == LOCK_LAST)) begin
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (lock_miss && (miss_cnt == LOSS_LAST)) begin
            state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // Run-length counters restart from zero on every state change so each state starts a fresh run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (seed_load) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      if (hunt_cmp) begin
        if (mismatch || (match_cnt == LOCK_LAST)) begin
          match_cnt <= '0;
        end else begin
          match_cnt <= match_cnt + 8'd1;
        end
      end
      if (lock_cmp) begin
        if (!mismatch || (miss_cnt == LOSS_LAST)) begin
          miss_cnt <= '0;
        end else begin
          miss_cnt <= miss_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      error <= lock_miss;
      if (clear) begin
        err_count <= '0;
      end else if (lock_miss && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

`ifdef LFSR_CHECKER_BITCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_count <= '0;
    end else if (clear) begin
      bit_count <= '0;
    end else if (lock_cmp && (bit_count != '1)) begin
      bit_count <= bit_count + 32'd1;
    end
  end
`else
  always_comb begin
    bit_count = '0;
  end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a behavioural generator + checker model pushes expected
// outputs per clock; a monitor pops and compares after each rising edge.
module tb_lfsr_checker;

  localparam int unsigned LC = 16;
  localparam int unsigned LL = 8;
  localparam int unsigned EW = 4;
  localparam int unsigned ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          seed_load = 1'b0;
  logic          enable = 1'b0;
  logic          in_bit = 1'b0;
  logic          clear = 1'b0;
  logic          locked;
  logic          error;
  logic [EW-1:0] err_count;
  logic [31:0]   bit_count;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_COUNT(LC), .LOSS_LIMIT(LL), .ERR_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .enable(enable), .in(in_bit),
    .clear(clear), .locked(locked), .error(error), .err_count(err_count), .bit_count(bit_count)
  );

  typedef struct {
    bit          lk;
    bit          er;
    int unsigned ec;
    logic [31:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Generator model and reference checker model
  bit [15:0]       g_s;
  bit              g_o;
  bit [15:0]       m_ref;
  bit              m_exp, m_enq, m_slip, m_lk;
  int unsigned     m_match, m_miss, m_err;
  longint unsigned m_bits;
  bit              hist[$];

  // Multiply by x modulo x^16 + x^5 + x^4 + x^3 + 1.
  function automatic bit [15:0] lfsr_adv(input bit [15:0] s);
    bit [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ 16'h0039;
    return t;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    g_s = 16'hAAAA; g_o = 1'b0;
    m_ref = 16'hAAAA; m_exp = 1'b0; m_enq = 1'b0; m_slip = 1'b0; m_lk = 1'b0;
    m_match = 0; m_miss = 0; m_err = 0; m_bits = 0;
  endfunction

  task automatic step(input bit sl, input bit en, input bit rx, input bit clr);
    bit   cmp, hit, pulse, nslip;
    exp_t e;
    seed_load = sl; enable = en; in_bit = rx; clear = clr;
    cmp = m_enq; hit = (rx == m_exp); pulse = 1'b0; nslip = 1'b0;
    if (sl) begin
      m_lk = 1'b0; m_match = 0; m_miss = 0;
    end else if (cmp) begin
      if (!m_lk) begin
        if (hit) begin
          m_match++;
          if (m_match == LC) begin m_lk = 1'b1; m_match = 0; end
        end else begin
          m_match = 0; nslip = 1'b1;
        end
      end else begin
        if (m_bits != 64'hFFFF_FFFF) m_bits++;
        if (!hit) begin
          pulse = 1'b1;
          if (m_err != ERR_MAX) m_err++;
          m_miss++;
          if (m_miss == LL) begin m_lk = 1'b0; m_miss = 0; end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (clr) begin m_err = 0; m_bits = 0; end
    m_exp = m_ref[0];
    if (sl) m_ref = 16'hAAAA;
    else if (en && !m_slip) m_ref = lfsr_adv(m_ref);
    m_slip = nslip;
    m_enq = en;
    g_o = g_s[0];
    if (sl) g_s = 16'hAAAA;
    else if (en) g_s = lfsr_adv(g_s);
    e.lk = m_lk; e.er = pulse; e.ec = m_err;
`ifdef LFSR_CHECKER_BITCNT_EN
    e.bc = m_bits[31:0];
`else
    e.bc = 32'd0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("locked", {31'd0, locked}, {31'd0, e.lk});
      check("error", {31'd0, error}, {31'd0, e.er});
      check("err_count", {28'd0, err_count}, e.ec);
      check("bit_count", bit_count, e.bc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_err_count", {28'd0, err_count}, 32'd0);
    check("rst_bit_count", bit_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++)
      step(1'b0, $urandom_range(9) != 0, g_o, $urandom_range(199) == 0);
    check("loopback_locked", {31'd0, locked}, 32'd1);
    check("loopback_err", {28'd0, err_count}, 32'd0);

    repeat (5) step(1'b0, 1'b1, g_o, 1'b0);
    step(1'b0, 1'b1, ~g_o, 1'b0);
    repeat (5) step(1'b0, 1'b1, g_o, 1'b0);
    check("single_err", {28'd0, err_count}, 32'd1);
    check("single_locked", {31'd0, locked}, 32'd1);

    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, ~g_o, 1'b0);
      repeat ($urandom_range(12, 4)) step(1'b0, 1'b1, g_o, 1'b0);
    end
    check("sat_err", {28'd0, err_count}, ERR_MAX);
    check("sat_locked", {31'd0, locked}, 32'd1);
    step(1'b0, 1'b1, g_o, 1'b1);
    check("clear_err", {28'd0, err_count}, 32'd0);
    check("clear_bits", bit_count, 32'd0);
    check("clear_locked", {31'd0, locked}, 32'd1);

    for (int i = 0; i < int'(LL); i++) step(1'b0, 1'b1, ~g_o, 1'b0);
    check("loss_locked", {31'd0, locked}, 32'd0);
    check("loss_err", {28'd0, err_count}, LL);
    repeat (30) step(1'b0, 1'b1, ~g_o, 1'b0);
    check("hunt_no_count", {28'd0, err_count}, LL);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    hist.delete();
    for (int i = 0; i < 2000; i++) begin
      hist.push_front(g_o);
      if (hist.size() > 6) void'(hist.pop_back());
      step(1'b0, 1'b1, (hist.size() > 5) ? hist[5] : 1'b0, $urandom_range(299) == 0);
    end

    #2;
    reset = 1'b0;
    #1;
    check("arst_locked", {31'd0, locked}, 32'd0);
    check("arst_error", {31'd0, error}, 32'd0);
    check("arst_err_count", {28'd0, err_count}, 32'd0);
    check("arst_bit_count", bit_count, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    repeat (LC) step(1'b0, 1'b1, g_o, 1'b0);
    check("relock_early", {31'd0, locked}, 32'd0);
    step(1'b0, 1'b1, g_o, 1'b0);
    check("relock", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 200; i++)
      step(1'b0, $urandom_range(3) != 0, g_o, 1'b0);
    check("relock_err", {28'd0, err_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
